// File: rtl/spi_pixel_framebuffer.sv
// Double-buffered pixel store between the SPI byte receiver and a
// WS281x-style serializer, with frame commit/cancel and overflow flag.
module spi_pixel_framebuffer #(
    parameter int NUM_LEDS      = 8,
    parameter int BYTES_PER_LED = 3,
    parameter int ORDER         = 0,
    localparam int DEPTH = NUM_LEDS * BYTES_PER_LED,
    localparam int AW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          frame_end,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          frame_sync,
    input  logic          pix_req,
    input  logic [AW-1:0] pix_addr,
    output logic [7:0]    pix_red,
    output logic [7:0]    pix_green,
    output logic [7:0]    pix_blue,
    output logic [7:0]    pix_white,
    output logic          pix_valid,
    output logic          disp_bank,
    output logic          commit_pending,
    output logic          overflow
);

    localparam int IW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NLEDS_C = CW'(NUM_LEDS);
    localparam logic [CW-1:0] BPL_C   = CW'(BYTES_PER_LED);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [2][DEPTH];
    logic [CW-1:0] count [2];
    logic [CW-1:0] index;
    logic [CW-1:0] wr_index;
    logic [CW-1:0] final_index;
    logic          store;
    logic          drop;
    logic          close;
    logic          swap;
    logic          write_bank;
    logic [CW-1:0] base;
    logic          in_range;
    logic [7:0]    rd [4];
    logic [7:0]    red_next;
    logic [7:0]    green_next;
    logic [7:0]    blue_next;
    logic [7:0]    white_next;

    assign write_bank  = ~disp_bank;
    assign final_index = wr_index + CW'(store);
    // A frame_start cancels any pending commit, so it also blocks the swap.
    assign swap = frame_sync && commit_pending && !frame_start;

    // Collector state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Collector next-state: frame_start always (re)opens a frame.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (frame_start) state_next = COLLECT;
            COLLECT: begin
                if (frame_start)    state_next = COLLECT;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Collector decode: byte store, byte drop and frame close strobes.
    always_comb begin
        wr_index = frame_start ? '0 : index;
        store    = 1'b0;
        drop     = 1'b0;
        close    = 1'b0;
        if (frame_start) begin
            store = rx_valid;
        end else if (state == COLLECT) begin
            store = rx_valid && (index < DEPTH_C);
            drop  = rx_valid && (index == DEPTH_C);
            close = frame_end;
        end
    end

    // Frame bookkeeping: index, overflow, counts, commit and bank swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index          <= '0;
            overflow       <= 1'b0;
            commit_pending <= 1'b0;
            disp_bank      <= 1'b0;
            count[0]       <= '0;
            count[1]       <= '0;
        end else begin
            if (frame_start || store) index <= final_index;
            if (frame_start)  overflow <= 1'b0;
            else if (drop)    overflow <= 1'b1;
            if (swap) begin
                disp_bank      <= ~disp_bank;
                commit_pending <= 1'b0;
            end
            if (frame_start) begin
                commit_pending <= 1'b0;
            end else if (close && final_index != '0) begin
                count[write_bank] <= final_index;
                commit_pending    <= 1'b1;
            end
        end
    end

    // Pixel storage; contents are don't-care until a count covers them.
    always_ff @(posedge clk) begin
        if (store) mem[write_bank][IW'(wr_index)] <= rx_data;
    end

    // Read decode: bytes past the display count or past the chain read 0.
    always_comb begin
        base     = CW'(pix_addr) * BPL_C;
        in_range = CW'(pix_addr) < NLEDS_C;
        for (int k = 0; k < 4; k++) begin
            rd[k] = 8'h00;
            if (k < BYTES_PER_LED && in_range
                && (base + CW'(k)) < count[disp_bank])
                rd[k] = mem[disp_bank][IW'(base + CW'(k))];
        end
        if (ORDER == 0) begin
            green_next = rd[0];
            red_next   = rd[1];
        end else begin
            red_next   = rd[0];
            green_next = rd[1];
        end
        blue_next  = rd[2];
        white_next = (BYTES_PER_LED == 4) ? rd[3] : 8'h00;
    end

    // Registered read port; colours hold between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_red   <= 8'h00;
            pix_green <= 8'h00;
            pix_blue  <= 8'h00;
            pix_white <= 8'h00;
        end else begin
            pix_valid <= pix_req;
            if (pix_req) begin
                pix_red   <= red_next;
                pix_green <= green_next;
                pix_blue  <= blue_next;
                pix_white <= white_next;
            end
        end
    end

endmodule

// File: tb/tb_spi_pixel_framebuffer.sv
// Directed bench for spi_pixel_framebuffer: an RGB/GRB instance and an
// RGBW/RGB-order instance share the frame stimulus; reads are scoreboarded.
module tb_spi_pixel_framebuffer;

    typedef struct {
        string      tag;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic       pix_req = 1'b0;
    logic [2:0] pix_addr = 3'd0;
    logic       pix_req4 = 1'b0;
    logic [0:0] pix_addr4 = 1'b0;

    logic [7:0] red, green, blue, white;
    logic       valid, bank, pending, ovf;
    logic [7:0] red4, green4, blue4, white4;
    logic       valid4, bank4, pending4, ovf4;

    int errors = 0;
    int checks = 0;
    int nrd = 0;
    exp_t q0[$];
    exp_t q4[$];
    logic [7:0] disp_model[$];
    logic [7:0] bytes[$];
    logic exp_bank = 1'b0;

    spi_pixel_framebuffer #(.NUM_LEDS(8), .BYTES_PER_LED(3), .ORDER(0)) dut (
        .clk(clk), .reset(rst), .frame_start(frame_start),
        .frame_end(frame_end), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_sync(frame_sync), .pix_req(pix_req), .pix_addr(pix_addr),
        .pix_red(red), .pix_green(green), .pix_blue(blue),
        .pix_white(white), .pix_valid(valid), .disp_bank(bank),
        .commit_pending(pending), .overflow(ovf)
    );

    spi_pixel_framebuffer #(.NUM_LEDS(2), .BYTES_PER_LED(4), .ORDER(1)) dut4 (
        .clk(clk), .reset(rst), .frame_start(frame_start),
        .frame_end(frame_end), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_sync(frame_sync), .pix_req(pix_req4), .pix_addr(pix_addr4),
        .pix_red(red4), .pix_green(green4), .pix_blue(blue4),
        .pix_white(white4), .pix_valid(valid4), .disp_bank(bank4),
        .commit_pending(pending4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid read pops one expected pixel.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid) begin
            if (q0.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check({e.tag, "_r"}, {24'd0, red}, {24'd0, e.r});
                check({e.tag, "_g"}, {24'd0, green}, {24'd0, e.g});
                check({e.tag, "_b"}, {24'd0, blue}, {24'd0, e.b});
                check({e.tag, "_w"}, {24'd0, white}, {24'd0, e.w});
            end
        end
        if (!rst && valid4) begin
            if (q4.size() == 0) begin
                check("unexpected_valid4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check({e.tag, "_r"}, {24'd0, red4}, {24'd0, e.r});
                check({e.tag, "_g"}, {24'd0, green4}, {24'd0, e.g});
                check({e.tag, "_b"}, {24'd0, blue4}, {24'd0, e.b});
                check({e.tag, "_w"}, {24'd0, white4}, {24'd0, e.w});
            end
        end
    end

    function automatic logic [7:0] model_byte(input int i);
        return (i < disp_model.size()) ? disp_model[i] : 8'h00;
    endfunction

    // GRB wire order, 3 bytes per pixel, 8 pixels.
    function automatic exp_t model_pix(input int a, input string tag);
        exp_t e;
        e.tag = tag;
        e.g = model_byte(a * 3);
        e.r = model_byte(a * 3 + 1);
        e.b = model_byte(a * 3 + 2);
        e.w = 8'h00;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data[$]);
        start_frame();
        foreach (data[i]) put_byte(data[i]);
        end_frame();
    endtask

    task automatic sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic read(input int a);
        pix_req  = 1'b1;
        pix_addr = 3'(a);
        q0.push_back(model_pix(a, $sformatf("rd%0d_a%0d", nrd, a)));
        nrd++;
        tick();
        pix_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) read(a);
    endtask

    // Model the display taking the committed bytes (first 24 kept).
    task automatic commit_model(input logic [7:0] data[$]);
        disp_model = {};
        foreach (data[i]) if (i < 24) disp_model.push_back(data[i]);
        exp_bank = ~exp_bank;
    endtask

    initial begin
        exp_t e4;
        // Reset state
        tick(); tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_bank", {31'd0, bank}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_rgbw", {red, green, blue, white}, 32'd0);
        rst = 1'b0;
        tick();
        read(0);
        check("rst_bank_after_read", {31'd0, bank}, 32'd0);

        // Full 24-byte frame
        bytes = {};
        for (int i = 1; i <= 24; i++) bytes.push_back(8'(i));
        send_frame(bytes);
        check("full_pending", {31'd0, pending}, 32'd1);
        check("full_bank_pre", {31'd0, bank}, 32'd0);
        sync();
        commit_model(bytes);
        check("full_bank", {31'd0, bank}, {31'd0, exp_bank});
        check("full_pending_clr", {31'd0, pending}, 32'd0);
        read(2);
        read_all();
        tick();
        check("hold_green", {24'd0, green}, 32'h16);

        // Short frame blanks the tail
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(bytes);
        sync();
        commit_model(bytes);
        check("short_bank", {31'd0, bank}, {31'd0, exp_bank});
        read_all();

        // Overflow frame of 26 bytes
        bytes = {};
        for (int i = 0; i < 26; i++) bytes.push_back(8'(8'h30 + i));
        start_frame();
        for (int i = 0; i < 24; i++) put_byte(bytes[i]);
        check("ovf_at_24", {31'd0, ovf}, 32'd0);
        put_byte(bytes[24]);
        check("ovf_at_25", {31'd0, ovf}, 32'd1);
        put_byte(bytes[25]);
        end_frame();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        check("ovf_pending", {31'd0, pending}, 32'd1);
        sync();
        commit_model(bytes);
        check("ovf_bank", {31'd0, bank}, {31'd0, exp_bank});
        read(7);
        read(0);

        // Empty frame: clears overflow, commits nothing
        start_frame();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        end_frame();
        check("empty_no_commit", {31'd0, pending}, 32'd0);

        // Frame A superseded by frame B before any sync
        bytes = {};
        for (int i = 0; i < 12; i++) bytes.push_back(8'(8'h41 + i));
        send_frame(bytes);
        check("a_pending", {31'd0, pending}, 32'd1);
        start_frame();
        check("b_cancel", {31'd0, pending}, 32'd0);
        bytes = {};
        for (int i = 0; i < 6; i++) bytes.push_back(8'(8'h51 + i));
        foreach (bytes[i]) put_byte(bytes[i]);
        end_frame();
        check("b_bank_pre", {31'd0, bank}, {31'd0, exp_bank});
        sync();
        commit_model(bytes);
        check("b_bank", {31'd0, bank}, {31'd0, exp_bank});
        sync();
        check("b_single_toggle", {31'd0, bank}, {31'd0, exp_bank});
        read_all();

        // frame_end coincident with frame_sync defers the swap
        bytes = {};
        for (int i = 0; i < 6; i++) bytes.push_back(8'(8'h61 + i));
        start_frame();
        foreach (bytes[i]) put_byte(bytes[i]);
        frame_end  = 1'b1;
        frame_sync = 1'b1;
        tick();
        frame_end  = 1'b0;
        frame_sync = 1'b0;
        check("coinc_no_swap", {31'd0, bank}, {31'd0, exp_bank});
        check("coinc_pending", {31'd0, pending}, 32'd1);
        sync();
        commit_model(bytes);
        check("coinc_swap", {31'd0, bank}, {31'd0, exp_bank});
        check("coinc_pending_clr", {31'd0, pending}, 32'd0);
        read(0);
        read(1);

        // RGBW with RGB wire order on the second instance
        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(bytes);
        sync();
        commit_model(bytes);
        check("rgbw_bank", {31'd0, bank4}, {31'd0, exp_bank});
        read(0);
        read(1);
        e4 = '{tag: "rgbw_a0", r: 8'h10, g: 8'h20, b: 8'h30, w: 8'h40};
        q4.push_back(e4);
        pix_req4 = 1'b1; pix_addr4 = 1'b0;
        tick();
        e4 = '{tag: "rgbw_a1", r: 8'h00, g: 8'h00, b: 8'h00, w: 8'h00};
        q4.push_back(e4);
        pix_addr4 = 1'b1;
        tick();
        pix_req4 = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && (q0.size() + q4.size()) != 0; i++) tick();
        tick();
        check("drain", 32'(q0.size() + q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
